// File: rtl/l2_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// l2_port_arbiter_pkg : shared types and defaults for the L2 port arbiter
// Rev 1.0
// ============================================================================
package l2_port_arbiter_pkg;

  localparam int c_line_w = 256;
  localparam int c_addr_w = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

endpackage : l2_port_arbiter_pkg
`default_nettype wire

// File: rtl/l2_port_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// rr_arbiter2 : two-way round-robin grant (bit 0 = I side, bit 1 = D side)
// Rev 1.0
// ============================================================================
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // On a tie the side that was not served last wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// l2_port_arbiter : shares the single L2 port between the L1I and L1D miss paths
// Rev 1.0
// ============================================================================
module l2_port_arbiter
  import l2_port_arbiter_pkg::*;
#(
  parameter int LINE_W = c_line_w,
  parameter int ADDR_W = c_addr_w
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic              l2_read_or_write
);

  arb_state_t        r_state;
  logic              r_last_grant;
  logic              r_op_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;
  logic              r_i_resp;
  logic              r_d_resp;

  logic              w_d_req;
  logic [1:0]        w_gnt;
  logic              w_busy;

  assign w_d_req = d_read | d_write;

  rr_arbiter2 u_rr_arbiter2 (
    .req        ({w_d_req, i_read}),
    .last_grant (r_last_grant),
    .gnt        (w_gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b0;
      r_op_write   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_i_resp     <= 1'b0;
      r_d_resp     <= 1'b0;
    end else begin
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          // A D request with both read and write high is a write-back.
          if (w_gnt[1]) begin
            r_addr     <= d_address;
            r_wdata    <= d_wdata;
            r_op_write <= d_write;
            r_state    <= BUSY_D;
          end else if (w_gnt[0]) begin
            r_addr     <= i_address;
            r_wdata    <= '0;
            r_op_write <= 1'b0;
            r_state    <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (l2_resp) begin
            r_i_rdata    <= l2_rdata;
            r_i_resp     <= 1'b1;
            r_last_grant <= 1'b0;
            r_state      <= RESP;
          end
        end
        BUSY_D: begin
          if (l2_resp) begin
            if (!r_op_write) begin
              r_d_rdata <= l2_rdata;
            end
            r_d_resp     <= 1'b1;
            r_last_grant <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // L2 strobes are decoded purely from state and the latched op.
  assign w_busy           = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign l2_read          = w_busy & ~r_op_write;
  assign l2_write         = w_busy &  r_op_write;
  assign l2_read_or_write = w_busy;
  assign l2_address       = r_addr;
  assign l2_wdata         = r_wdata;
  assign i_rdata          = r_i_rdata;
  assign d_rdata          = r_d_rdata;
  assign i_resp           = r_i_resp;
  assign d_resp           = r_d_resp;

endmodule : l2_port_arbiter
`default_nettype wire

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Arbitrates the single L2 cache port between the L1 instruction cache miss path and the L1 data cache miss path. Sits between the two L1 caches and the L2 cache. Grants one line-sized transaction at a time and latches the winner's address and write data for the whole transaction. Returns read data and a one-cycle response to the winner only, and drives the activity strobe consumed by the performance counter.

## Interface
- LINE_W, 256, cache line width in bits
- ADDR_W, 32, line address width; low log2(LINE_W/8) bits are passed through unmodified
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- i_read  in  1  L1I line read request; held until i_resp
- i_address  in  ADDR_W  L1I request address
- i_rdata  out  LINE_W  line returned to L1I
- i_resp  out  1  one-cycle completion pulse to L1I
- d_read  in  1  L1D line read request; held until d_resp
- d_write  in  1  L1D line write-back request; held until d_resp
- d_address  in  ADDR_W  L1D request address
- d_wdata  in  LINE_W  L1D write-back line
- d_rdata  out  LINE_W  line returned to L1D
- d_resp  out  1  one-cycle completion pulse to L1D
- l2_read / l2_write  out  1 each  request to L2; held until l2_resp
- l2_address  out  ADDR_W  latched address of the granted request
- l2_wdata  out  LINE_W  latched write data
- l2_rdata  in  LINE_W  L2 read data, valid with l2_resp
- l2_resp  in  1  L2 completion pulse
- l2_read_or_write  out  1  l2_read | l2_write, for the perf counter

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE
  - With no request, stay in IDLE.
  - With exactly one requester, grant it.
  - With both requesting, grant the side not served last (`last_grant` bit: 0=I, 1=D). Reset value of `last_grant` is 0, so D wins the first tie.
  - On grant, latch address, wdata and op (read/write) into registers, then enter BUSY_I or BUSY_D.
  - A D request with d_read and d_write both high is treated as a write.
- BUSY_x
  - Drive l2_read/l2_write from the latched op and l2_address/l2_wdata from the latched registers.
  - Requester input changes are ignored while busy.
  - On l2_resp, latch l2_rdata into the winner's rdata register, update `last_grant`, and go to RESP.
- RESP
  - Pulse the winner's resp for exactly one cycle, with the other resp low and l2_read/l2_write low, then go to IDLE.
  - A requester sees resp and drops its request by the following cycle. IDLE therefore never re-grants a completed request.
- i_rdata/d_rdata hold their last value until the next read completion on that side. Writes do not update d_rdata.
- Reset (mid-transaction included) returns the block to IDLE with all outputs low and latched registers cleared. Any L2 transaction in flight is abandoned; L2 is reset by the same rst_n.

## Timing
- Reset values: every output is 0, state is IDLE, last_grant is 0.
- Grant latency: a request seen in IDLE at edge t gives l2_read/l2_write high during cycle t+1.
- Response: l2_resp sampled at edge t gives x_resp high during cycle t+1 only, with rdata valid in the same cycle.
- Minimum turnaround is 3 cycles plus the L2 latency (grant, L2 wait, RESP). IDLE lasts at least one cycle between transactions.
- If l2_resp arrives in the same cycle the request first asserts, it is accepted as completion.
- No combinational path exists from any input to l2_*, i_resp or d_resp. All are registered or decoded from state and latches.
- l2_rdata is never forwarded combinationally to i_rdata or d_rdata.

## Structure
- Shared package (with the cache types): `arb_state_t` enum {IDLE, BUSY_I, BUSY_D, RESP} and the LINE_W default constant.
- One sub-module: `rr_arbiter2`. It is a 2-way round-robin grant, combinational from req[1:0] and last_grant, returning gnt[1:0].
- The FSM, latches and output decode live in the top module.

## Test plan
- Single I read: i_read=1 with i_address=0x0000_1000, L2 responds after 5 cycles with rdata=all-A5 → l2_read high from cycle 1, l2_address=0x1000, i_resp pulses exactly once with i_rdata=all-A5, d_resp stays 0.
- Tie after reset: i_read and d_read asserted together → D is served first, then I. Issue a second tie after that → D first again, then I (alternating by last_grant).
- D write-back: d_write=1, d_address=0x8000_0040, d_wdata=pattern 0x0123… → l2_write=1 with the latched data. Changing d_wdata mid-transaction does not affect l2_wdata. d_rdata is unchanged after d_resp.
- Back-to-back: I read held while a D write is busy → I is granted in the IDLE cycle after RESP, and l2_read_or_write goes low for at least 2 cycles between the two transactions.
- Reset mid-transaction: rst_n=0 during BUSY_D → at the next edge all outputs are 0 and state is IDLE. After release, a pending i_read is granted normally.
- Zero-wait L2: l2_resp tied high → each transaction completes in 3 cycles and resp never pulses twice for one request.
